// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I opcode, NOP and hazard FSM encodings
package core_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_FLUSH    = 2'd2
    } hazard_state_e;

endpackage

// File: rtl/decode_src_use.sv
// rtl/decode_src_use.sv - maps an instruction to its source register usage
module decode_src_use
    import core_pkg::*;
(
    input  logic [31:0] instr,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2
);

    assign rs1 = instr[19:15];
    assign rs2 = instr[24:20];

    // LUI, AUIPC, JAL and unknown opcodes read no source register
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (instr[6:0])
            OP_OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            OP_STORE, OP_BRANCH, OP_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - IF/ID register with load-use, redirect and backpressure control
module decode_hazard_ctrl
    import core_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_ready,
    output logic [31:0]      id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic             id_valid,
    output logic             id_issue,
    output logic             pc_hold,
    output logic [1:0]       hazard_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hazard_state_e    state_q, state_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [XLEN-1:0]  id_pc_q, id_pc_d;
    logic             id_valid_q, id_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       uses_rs1, uses_rs2;
    logic [4:0] rs1, rs2;
    logic       load_use;

    decode_src_use u_src_use (
        .instr    (id_instr_q),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    assign load_use = id_valid_q & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));

    // next-state, IF/ID update and stall/issue outputs; redirect > load-use > backpressure > advance
    always_comb begin
        state_d     = state_q;
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        id_issue    = 1'b0;
        pc_hold     = 1'b0;

        if (ex_redirect) begin
            // squash from any state; the wrong-path fetch is dropped next cycle in FLUSH
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            state_d    = HZ_FLUSH;
            if (flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (load_use) begin
                        pc_hold = 1'b1;
                        state_d = HZ_LU_STALL;
                        if (stall_cnt_q != {CNT_W{1'b1}}) begin
                            stall_cnt_d = stall_cnt_q + 1'b1;
                        end
                    end else if (!ex_ready) begin
                        pc_hold = 1'b1;
                    end else begin
                        id_issue   = id_valid_q;
                        id_instr_d = if_instr;
                        id_pc_d    = if_pc;
                        id_valid_d = if_valid;
                    end
                end
                HZ_LU_STALL: begin
                    // the load has moved to MEM and forwards, so no re-check of load-use
                    state_d = HZ_RUN;
                    if (!ex_ready) begin
                        pc_hold = 1'b1;
                    end else begin
                        id_issue   = id_valid_q;
                        id_instr_d = if_instr;
                        id_pc_d    = if_pc;
                        id_valid_d = if_valid;
                    end
                end
                HZ_FLUSH: begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                    state_d    = HZ_RUN;
                end
                default: begin
                    state_d = HZ_RUN;
                end
            endcase
        end

        if (rst) begin
            id_issue = 1'b0;
            pc_hold  = 1'b0;
        end
    end

    // state, IF/ID and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HZ_RUN;
            id_instr_q  <= NOP_INSTR;
            id_pc_q     <= '0;
            id_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign id_instr     = id_instr_q;
    assign id_pc        = id_pc_q;
    assign id_valid     = id_valid_q;
    assign hazard_state = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb/tb_decode_hazard_ctrl.sv - directed self-checking bench for decode_hazard_ctrl
module tb_decode_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_ADD  = 32'h0020_81B3;
    localparam logic [31:0] I_LUI  = 32'h0000_11B7;
    localparam logic [31:0] I_NOP  = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic [31:0]      if_instr;
    logic [XLEN-1:0]  if_pc;
    logic             ex_valid;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_redirect;
    logic             ex_ready;
    logic [31:0]      id_instr;
    logic [XLEN-1:0]  id_pc;
    logic             id_valid;
    logic             id_issue;
    logic             pc_hold;
    logic [1:0]       hazard_state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    decode_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .ex_ready     (ex_ready),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .id_issue     (id_issue),
        .pc_hold      (pc_hold),
        .hazard_state (hazard_state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    initial begin
        rst = 1'b1;
        if_valid = 1'b0; if_instr = I_NOP; if_pc = '0;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        ex_redirect = 1'b0; ex_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_state",    32'(hazard_state), 32'd0);
        check_eq("rst_instr",    id_instr, I_NOP);
        check_eq("rst_pc",       id_pc, 32'd0);
        check_eq("rst_valid",    32'(id_valid), 32'd0);
        check_eq("rst_issue",    32'(id_issue), 32'd0);
        check_eq("rst_hold",     32'(pc_hold), 32'd0);
        check_eq("rst_stall",    32'(stall_cnt), 32'd0);
        check_eq("rst_flush",    32'(flush_cnt), 32'd0);
        rst = 1'b0;

        // basic one-edge latency into ID, issue the following cycle
        fetch(I_ADDI, 32'h100);
        tick();
        check_eq("adv_valid", 32'(id_valid), 32'd1);
        check_eq("adv_instr", id_instr, I_ADDI);
        check_eq("adv_pc",    id_pc, 32'h100);
        check_eq("adv_issue", 32'(id_issue), 32'd1);
        check_eq("adv_stall", 32'(stall_cnt), 32'd0);

        // load-use on rs1 of ADD x3,x1,x2
        fetch(I_ADD, 32'h104);
        tick();
        check_eq("lu_id_add", id_instr, I_ADD);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd1;
        fetch(I_NOP, 32'h108);
        #1;
        check_eq("lu_issue0", 32'(id_issue), 32'd0);
        check_eq("lu_hold1",  32'(pc_hold), 32'd1);
        check_eq("lu_state0", 32'(hazard_state), 32'd0);
        tick();
        check_eq("lu_state1", 32'(hazard_state), 32'd1);
        check_eq("lu_held",   id_instr, I_ADD);
        check_eq("lu_pcheld", id_pc, 32'h104);
        check_eq("lu_cnt",    32'(stall_cnt), 32'd1);
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        #1;
        check_eq("lu_issue1", 32'(id_issue), 32'd1);
        check_eq("lu_hold0",  32'(pc_hold), 32'd0);
        tick();
        check_eq("lu_state_back", 32'(hazard_state), 32'd0);
        check_eq("lu_next",       id_instr, I_NOP);

        // ex_rd = 0 never stalls
        fetch(I_ADD, 32'h10C);
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
        fetch(I_LUI, 32'h110);
        #1;
        check_eq("rd0_issue", 32'(id_issue), 32'd1);
        check_eq("rd0_hold",  32'(pc_hold), 32'd0);
        tick();
        check_eq("rd0_state", 32'(hazard_state), 32'd0);
        check_eq("lui_in_id", id_instr, I_LUI);
        // LUI reads no source: ex_rd = 3 must not stall
        ex_rd = 5'd3;
        #1;
        check_eq("lui_issue", 32'(id_issue), 32'd1);
        check_eq("lui_hold",  32'(pc_hold), 32'd0);

        // redirect coincident with a load-use on rs2 of ADD
        ex_valid = 1'b0;
        fetch(I_ADD, 32'h114);
        tick();
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2; ex_redirect = 1'b1;
        #1;
        check_eq("rdr_hold",  32'(pc_hold), 32'd0);
        check_eq("rdr_issue", 32'(id_issue), 32'd0);
        tick();
        check_eq("rdr_state", 32'(hazard_state), 32'd2);
        check_eq("rdr_valid", 32'(id_valid), 32'd0);
        check_eq("rdr_flush", 32'(flush_cnt), 32'd1);
        check_eq("rdr_stall", 32'(stall_cnt), 32'd1);
        ex_redirect = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
        fetch(I_ADDI, 32'h118);
        #1;
        check_eq("fl_issue", 32'(id_issue), 32'd0);
        check_eq("fl_hold",  32'(pc_hold), 32'd0);
        tick();
        check_eq("fl_state", 32'(hazard_state), 32'd0);
        check_eq("fl_drop",  32'(id_valid), 32'd0);
        fetch(I_ADD, 32'h200);
        tick();
        check_eq("tgt_valid", 32'(id_valid), 32'd1);
        check_eq("tgt_pc",    id_pc, 32'h200);

        // three cycles of EX backpressure
        ex_ready = 1'b0;
        fetch(I_ADDI, 32'h204);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("bp_issue", 32'(id_issue), 32'd0);
            check_eq("bp_hold",  32'(pc_hold), 32'd1);
            tick();
            check_eq("bp_instr", id_instr, I_ADD);
            check_eq("bp_pc",    id_pc, 32'h200);
            check_eq("bp_state", 32'(hazard_state), 32'd0);
        end
        check_eq("bp_stall", 32'(stall_cnt), 32'd1);
        check_eq("bp_flush", 32'(flush_cnt), 32'd1);
        ex_ready = 1'b1;
        #1;
        check_eq("bp_resume", 32'(id_issue), 32'd1);
        tick();
        check_eq("bp_next", id_instr, I_ADDI);

        // saturate stall_cnt with 16 more load-use stalls
        fetch(I_ADD, 32'h300);
        tick();
        for (int i = 0; i < 16; i++) begin
            ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd1;
            tick();
            ex_valid = 1'b0; ex_mem_read = 1'b0;
            tick();
        end
        check_eq("sat_stall", 32'(stall_cnt), 32'hF);
        check_eq("sat_flush", 32'(flush_cnt), 32'd1);

        // reset while in LU_STALL
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd1;
        tick();
        check_eq("pre_rst_state", 32'(hazard_state), 32'd1);
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0;
        tick();
        check_eq("mid_rst_state", 32'(hazard_state), 32'd0);
        check_eq("mid_rst_valid", 32'(id_valid), 32'd0);
        check_eq("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check_eq("mid_rst_flush", 32'(flush_cnt), 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
